clock_enable_gen: RTL

Parametrised multi-channel clock-enable generator, the successor to the fixed single-channel motor divider. Each channel produces a one-cycle `tick` strobe every `div+1` system clocks, with a per-channel divisor programmable at runtime. New divisors take effect glitch-free at the channel's next wrap. Sits between the control logic and the motor/PWM/sensor timing blocks, which use `tick` as a clock enable on `clk`.

---
 rtl/clock_enable_gen.sv | 73 +++++++
 1 files changed

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: each channel emits a one-cycle tick
// every div+1 clocks, with runtime-programmable divisors that take effect
// at the channel's next wrap (or immediately when the channel is idle).
module clock_enable_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned DEFAULT_DIV = 400000,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  div_act  [NUM_CH];
  logic [CNT_W-1:0]  div_pend [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] reload;

  // Per-channel write decode and restart condition (wrap, sync or idle).
  // Out-of-range channel indices match no channel and are dropped.
  always_comb begin
    wr_hit = '0;
    reload = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = wr_en && (wr_ch == CH_W'(c));
      reload[c] = sync || !ch_en[c] || (cnt[c] >= div_act[c]);
    end
  end

  // Counter, divisor staging and registered strobes for every channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]      <= '0;
        div_act[c]  <= RST_DIV;
        div_pend[c] <= RST_DIV;
      end
      tick    <= '0;
      pending <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        tick[c] <= ch_en[c] && !sync && (cnt[c] == '0);
        if (reload[c]) begin
          // Restart point: a same-cycle write beats any staged divisor.
          cnt[c] <= '0;
          if (wr_hit[c]) begin
            div_act[c] <= wr_div;
          end else if (pending[c]) begin
            div_act[c] <= div_pend[c];
          end
          pending[c] <= 1'b0;
        end else begin
          cnt[c] <= cnt[c] + CNT_W'(1);
          if (wr_hit[c]) begin
            div_pend[c] <= wr_div;
            pending[c]  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
